// File: rtl/adf4351_cfg_if.sv
// adf4351_cfg_if: three-wire program bus plus status pins of an ADF4351.
// master: drives CLK/DATA/LE/CE/PDBRF, reads MUXOUT/LD. slave: the PLL side.
interface adf4351_cfg_if;
  logic CLK;
  logic DATA;
  logic LE;
  logic CE;
  logic PDBRF;
  logic MUXOUT;
  logic LD;

  modport master (
    output CLK,
    output DATA,
    output LE,
    output CE,
    output PDBRF,
    input  MUXOUT,
    input  LD
  );

  modport slave (
    input  CLK,
    input  DATA,
    input  LE,
    input  CE,
    input  PDBRF,
    output MUXOUT,
    output LD
  );
endinterface

// File: rtl/adf4351_cfg.sv
// adf4351_cfg: shifts six 32-bit words (R5..R0) to an ADF4351 on each
// toggle of update; drives CE/PDBRF and synchronises LD/MUXOUT.
// Ports: clk, rst (async, active-high), update (toggle request),
//   data_5..data_0 (payload bits [31:3]), busy, locked, muxout_s,
//   pll (adf4351_cfg_if.master: CLK, DATA, LE, CE, PDBRF, MUXOUT, LD).
// Param CLK_DIV: serial clock half-period in clk cycles (>= 1).
// Macro ADF4351_AUTO_INIT_EN: run one sequence on the first clock after
//   reset release without waiting for an update toggle.
module adf4351_cfg #(
  parameter int CLK_DIV = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          update,
  input  logic [28:0]   data_5,
  input  logic [28:0]   data_4,
  input  logic [28:0]   data_3,
  input  logic [28:0]   data_2,
  input  logic [28:0]   data_1,
  input  logic [28:0]   data_0,
  output logic          busy,
  output logic          locked,
  output logic          muxout_s,
  adf4351_cfg_if.master pll
);

  localparam int CW = $clog2(2 * CLK_DIV);

  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    GAP
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic [4:0]    bcnt;
  logic [2:0]    idx;
  logic [2:0]    nidx;
  logic [31:0]   shreg;
  logic [28:0]   snap [6];
  logic          pend;
  logic          upd_q;
  logic          arm;
  logic          ce;
  logic          pdbrf;
  logic          ld_s1;
  logic          ld_s2;
  logic          mux_s1;
  logic          mux_s2;

  logic req;
  logic auto_go;
  logic go;
  logic again;
  logic bit_end;
  logic half_end;
  logic last_bit;
  logic gap_end;
  logic load_seq;
  logic next_word;
  logic seq_done;

  // arm is low only on the first clock after reset; the update copy is
  // reloaded there, so coming out of reset never looks like a toggle.
  assign req = arm && (upd_q != update);

`ifdef ADF4351_AUTO_INIT_EN
  assign auto_go = !arm;
`else
  assign auto_go = 1'b0;
`endif

  assign go        = req || auto_go;
  assign again     = pend || req;
  assign bit_end   = (cnt == BIT_LAST);
  assign half_end  = (cnt == HALF_LAST);
  assign last_bit  = (bcnt == 5'd31);
  assign gap_end   = (state == GAP) && half_end;
  assign seq_done  = gap_end && (idx == 3'd0);
  assign next_word = gap_end && (idx != 3'd0);
  // A pending (or same-cycle) request chains straight into a new pass.
  assign load_seq  = ((state == IDLE) && go)
                  || (seq_done && again);
  assign nidx      = idx - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (go) state_n = SHIFT;
      end
      SHIFT: begin
        if (bit_end && last_bit) state_n = LATCH;
      end
      LATCH: begin
        if (half_end) state_n = GAP;
      end
      GAP: begin
        if (half_end) begin
          if (idx != 3'd0 || again) state_n = SHIFT;
          else                      state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    pll.CLK  = 1'b0;
    pll.DATA = 1'b0;
    pll.LE   = 1'b0;
    unique case (state)
      SHIFT: begin
        pll.CLK  = (cnt >= HALF);
        pll.DATA = shreg[31];
      end
      LATCH: begin
        pll.LE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pll.CE    = ce;
  assign pll.PDBRF = pdbrf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bcnt  <= '0;
      idx   <= '0;
      shreg <= '0;
      pend  <= 1'b0;
      upd_q <= 1'b0;
      arm   <= 1'b0;
      ce    <= 1'b0;
      pdbrf <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        snap[i] <= '0;
      end
    end else begin
      upd_q <= update;
      arm   <= 1'b1;
      ce    <= 1'b1;

      if (state_n != state || state == IDLE
          || (state == SHIFT && bit_end)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (load_seq || next_word) begin
        bcnt <= '0;
      end else if (state == SHIFT && bit_end) begin
        bcnt <= bcnt + 5'd1;
      end

      if (load_seq) begin
        idx   <= 3'd5;
        shreg <= {data_5, 3'd5};
        snap[5] <= data_5;
        snap[4] <= data_4;
        snap[3] <= data_3;
        snap[2] <= data_2;
        snap[1] <= data_1;
        snap[0] <= data_0;
      end else if (next_word) begin
        idx   <= nidx;
        shreg <= {snap[nidx], nidx};
      end else if (state == SHIFT && bit_end) begin
        shreg <= {shreg[30:0], 1'b0};
      end

      if (load_seq) begin
        pend <= 1'b0;
      end else if (state != IDLE && req) begin
        pend <= 1'b1;
      end

      if (seq_done) begin
        pdbrf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_s1  <= 1'b0;
      ld_s2  <= 1'b0;
      mux_s1 <= 1'b0;
      mux_s2 <= 1'b0;
    end else begin
      ld_s1  <= pll.LD;
      ld_s2  <= ld_s1;
      mux_s1 <= pll.MUXOUT;
      mux_s2 <= mux_s1;
    end
  end

  assign locked   = ld_s2;
  assign muxout_s = mux_s2;

endmodule

// File: tb/tb_adf4351_cfg.sv
// tb_adf4351_cfg: directed bench for adf4351_cfg with CLK_DIV=2.
// Offset-arithmetic reference model plus hand-computed word literals.
module tb_adf4351_cfg;
  localparam int N    = 2;
  localparam int WORD = 66 * N;
  localparam int SEQ  = 396 * N;

  logic        clk = 1'b0;
  logic        rst;
  logic        update;
  logic [28:0] d5, d4, d3, d2, d1, d0;
  logic        busy, locked, muxout_s;

  adf4351_cfg_if pll();

  adf4351_cfg #(.CLK_DIV(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .data_5   (d5),
    .data_4   (d4),
    .data_3   (d3),
    .data_2   (d2),
    .data_1   (d1),
    .data_0   (d0),
    .busy     (busy),
    .locked   (locked),
    .muxout_s (muxout_s),
    .pll      (pll.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a fixed 396N-cycle waveform indexed
  // by the offset from its start edge.
  int          cyc = 0;
  int          m_start, off, w, p, b;
  bit          m_act, m_pend, m_upd, m_arm, m_ce, m_pd, m_req, m_first;
  bit          m_l1, m_l2, m_x1, m_x2;
  logic [31:0] m_w [6];
  logic        e_clk, e_data, e_le, e_busy;

  task automatic m_begin();
    m_act   = 1;
    m_pend  = 0;
    m_start = cyc;
    m_w[5]  = {d5, 3'd5};
    m_w[4]  = {d4, 3'd4};
    m_w[3]  = {d3, 3'd3};
    m_w[2]  = {d2, 3'd2};
    m_w[1]  = {d1, 3'd1};
    m_w[0]  = {d0, 3'd0};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_pend = 0; m_upd = 0; m_arm = 0;
      m_ce = 0; m_pd = 0; m_l1 = 0; m_l2 = 0; m_x1 = 0; m_x2 = 0;
    end else begin
      cyc++;
      m_req   = m_arm && (update != m_upd);
      m_first = !m_arm;
      m_upd   = update;
      m_arm   = 1;
      m_ce    = 1;
      m_l2 = m_l1; m_l1 = pll.LD;
      m_x2 = m_x1; m_x1 = pll.MUXOUT;
      if (m_act) begin
        if (cyc - m_start == SEQ) begin
          m_pd = 1;
          if (m_pend || m_req) m_begin();
          else m_act = 0;
        end else if (m_req) begin
          m_pend = 1;
        end
      end else begin
`ifdef ADF4351_AUTO_INIT_EN
        if (m_req || m_first) m_begin();
`else
        if (m_req) m_begin();
`endif
      end
    end
    e_clk = 0; e_data = 0; e_le = 0; e_busy = m_act;
    if (m_act) begin
      off = cyc - m_start;
      w   = off / WORD;
      p   = off % WORD;
      if (p < 64 * N) begin
        b      = p / (2 * N);
        e_clk  = (p % (2 * N)) >= N;
        e_data = m_w[5 - w][31 - b];
      end else begin
        e_le = (p < 65 * N);
      end
    end
  end

  always @(negedge clk) begin
    chk("CLK",      {31'd0, pll.CLK},   {31'd0, e_clk});
    chk("DATA",     {31'd0, pll.DATA},  {31'd0, e_data});
    chk("LE",       {31'd0, pll.LE},    {31'd0, e_le});
    chk("busy",     {31'd0, busy},      {31'd0, e_busy});
    chk("CE",       {31'd0, pll.CE},    {31'd0, m_ce});
    chk("PDBRF",    {31'd0, pll.PDBRF}, {31'd0, m_pd});
    chk("locked",   {31'd0, locked},    {31'd0, m_l2});
    chk("muxout_s", {31'd0, muxout_s},  {31'd0, m_x2});
  end

  // Word capture as the PLL sees it: DATA on CLK rise, word on LE rise.
  logic [31:0] sh;
  logic [31:0] cap_q [$];
  int          le_cnt = 0;

  always @(posedge pll.CLK or posedge rst) begin
    if (rst) sh = '0;
    else     sh = {sh[30:0], pll.DATA};
  end

  always @(posedge pll.LE) begin
    cap_q.push_back(sh);
    le_cnt++;
  end

  int busy_run = 0, last_busy = 0, le_run = 0, last_le = 0;

  always @(negedge clk) begin
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy = busy_run;
      busy_run = 0;
    end
    if (pll.LE) le_run++;
    else begin
      if (le_run != 0) last_le = le_run;
      le_run = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, need 0", lim);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    update = 1'b0;
    d5 = 29'h000B0000;
    d4 = 29'h1234567;
    d3 = 29'h0ABCDEF;
    d2 = 29'h1555555;
    d1 = 29'h0AAAAAA;
    d0 = 29'h4000000;
    pll.LD = 1'b0;
    pll.MUXOUT = 1'b0;
    cycles(3);
    chk("rst_CLK",   {31'd0, pll.CLK},   32'd0);
    chk("rst_LE",    {31'd0, pll.LE},    32'd0);
    chk("rst_CE",    {31'd0, pll.CE},    32'd0);
    chk("rst_PDBRF", {31'd0, pll.PDBRF}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ce_release", {31'd0, pll.CE}, 32'd1);
`ifdef ADF4351_AUTO_INIT_EN
    chk("auto_busy", {31'd0, busy}, 32'd1);
    wait_idle(SEQ + 10);
    cap_q.delete();
    le_cnt = 0;
`else
    chk("idle_release", {31'd0, busy}, 32'd0);
`endif

    // Single sequence; data_3 changes during R4 shift.
    cycles(5);
`ifndef ADF4351_AUTO_INIT_EN
    chk("pdbrf_before", {31'd0, pll.PDBRF}, 32'd0);
`endif
    update = 1'b1;
    @(negedge clk);
    chk("busy_start", {31'd0, busy}, 32'd1);
    cycles(WORD + 10);
    d3 = 29'h1FFFFFFF;
    wait_idle(SEQ);
    cycles(2);
    chk("busy_len", last_busy, 32'd792);
    chk("le_width", last_le, 32'd2);
    chk("pdbrf_after", {31'd0, pll.PDBRF}, 32'd1);
    chk("words1", cap_q.size(), 32'd6);
    chk("r5_word", cap_q[0], 32'h00580005);
    chk("r4_word", cap_q[1], 32'h091A2B3C);
    chk("r3_word", cap_q[2], 32'h055E6F7B);
    chk("r2_word", cap_q[3], 32'h0AAAAAAA);
    chk("r1_word", cap_q[4], 32'h05555551);
    chk("r0_word", cap_q[5], 32'h20000000);

    // Toggle during a sequence: one extra pass, fresh snapshot.
    cap_q.delete();
    cycles(5);
    update = 1'b0;
    cycles(100);
    repeat (4) begin
      update = ~update;
      cycles(50);
    end
    d5 = 29'h1FFFFFFF;
    wait_idle(3 * SEQ);
    cycles(2);
    chk("busy_len_b2b", last_busy, 32'd1584);
    chk("words2", cap_q.size(), 32'd12);
    chk("seqa_r5", cap_q[0], 32'h00580005);
    chk("seqa_r3", cap_q[2], 32'hFFFFFFFB);
    chk("seqb_r5", cap_q[6], 32'hFFFFFFFD);
    cycles(200);
    chk("no_third", {31'd0, busy}, 32'd0);
    chk("words2_end", cap_q.size(), 32'd12);

    // Reset in the middle of R2.
    cap_q.delete();
    update = ~update;
    cycles(3 * WORD + 20);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_CLK",   {31'd0, pll.CLK},   32'd0);
    chk("mid_rst_DATA",  {31'd0, pll.DATA},  32'd0);
    chk("mid_rst_LE",    {31'd0, pll.LE},    32'd0);
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    chk("mid_rst_CE",    {31'd0, pll.CE},    32'd0);
    chk("mid_rst_PDBRF", {31'd0, pll.PDBRF}, 32'd0);
    cycles(3);
    chk("words_rst", cap_q.size(), 32'd3);
    rst = 1'b0;
    cycles(300);
`ifdef ADF4351_AUTO_INIT_EN
    chk("auto_after_rst", {31'd0, busy}, 32'd1);
    wait_idle(SEQ);
`else
    chk("idle_after_rst", {31'd0, busy}, 32'd0);
    chk("words_after_rst", cap_q.size(), 32'd3);
`endif

    // Synchronisers.
    cycles(2);
    pll.LD = 1'b1;
    @(negedge clk);
    chk("locked_1", {31'd0, locked}, 32'd0);
    @(negedge clk);
    chk("locked_2", {31'd0, locked}, 32'd1);
    pll.MUXOUT = 1'b1;
    @(negedge clk);
    chk("muxout_1", {31'd0, muxout_s}, 32'd0);
    @(negedge clk);
    chk("muxout_2", {31'd0, muxout_s}, 32'd1);
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
